reorder_buffer: RTL
===================

# reorder_buffer

Circular reorder buffer for the out-of-order RISC-V core. It allocates one entry per issued instruction and hands the entry index to the decoder as the rename tag. It captures results from the common data bus and retires entries strictly in program order onto the register-file commit port (rob_enable / rob_commit_index / rob_commit_rename / rob_commit_value). On a mispredicted branch it raises the pipeline-wide jump_wrong flush.

## Interface
- ROB_DEPTH, 16, number of entries (power of two)
- IDX_W, 4, log2(ROB_DEPTH); width of rename tags
- REG_W, 5, architectural register index width
- DATA_W, 32, data/PC width

- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rdy  in  1  global enable; 0 = every register holds
- issue_valid  in  1  decoder allocates an entry this cycle
- issue_has_rd  in  1  instruction writes an architectural register
- issue_rd  in  REG_W  destination register index
- rob_free_rename  out  IDX_W  tag to be assigned to the next issue (= tail)
- rob_full  out  1  no free entry
- rob_empty  out  1  no valid entry
- query_rename1 / query_rename2  in  IDX_W  tags the decoder is resolving
- query_ready1 / query_ready2  out  1  tagged result available
- query_value1 / query_value2  out  DATA_W  tagged result value
- cdb_valid  in  1  result broadcast
- cdb_rename  in  IDX_W  producing entry
- cdb_value  in  DATA_W  result (link value for jal/jalr)
- cdb_mispredict  in  1  branch resolved opposite to prediction
- cdb_target  in  DATA_W  correct next PC when cdb_mispredict=1
- rob_enable  out  1  commit to register file, one-cycle pulse
- rob_commit_index  out  REG_W  committed rd
- rob_commit_rename  out  IDX_W  committed entry tag
- rob_commit_value  out  DATA_W  committed value
- jump_wrong  out  1  flush pulse, one cycle
- jump_target  out  DATA_W  redirect PC, valid while jump_wrong=1

## Operation
- Per-entry state: busy, ready, has_rd, rd, value, mispredict, target. Global state: head, tail (IDX_W, wrap modulo ROB_DEPTH), count (IDX_W+1 bits), FSM {RUN, FLUSH}.
- rob_full = (count == ROB_DEPTH). rob_empty = (count == 0). rob_free_rename = tail. All three are combinational from registers.
- Issue: in RUN, with issue_valid && !rob_full, write entry[tail] with busy=1, ready=0, mispredict=0, has_rd and rd; then tail+1. Issue while full is dropped; it is the decoder's job to stall. A same-cycle commit does not unblock a full buffer.
- Writeback: in RUN, cdb_valid && entry[cdb_rename].busy sets ready=1 and stores value, mispredict and target. A CDB write to a non-busy entry is ignored.
- Query (combinational): if cdb_valid && cdb_rename == query_renameN, then readyN=1 and valueN=cdb_value (bypass). Otherwise readyN = busy && ready of the entry, and valueN = entry value.
- Commit: in RUN, if !rob_empty && entry[head].ready:
  - register rob_enable = has_rd, rob_commit_index = rd, rob_commit_rename = head, rob_commit_value = value;
  - clear busy, head+1, count-1.
  - Otherwise rob_enable <= 0.
- At most one issue and one commit per cycle. When both happen, count is unchanged.
- Mispredict: when the committing entry has mispredict=1, it still commits normally (rob_enable as above, so a jalr rd is written). In the same edge, latch target into jump_target and go to FLUSH.
- FLUSH (exactly one cycle):
  - jump_wrong=1, rob_enable=0;
  - all busy bits cleared; head=tail=count=0;
  - issue and CDB are ignored;
  - next state is RUN, with jump_wrong <= 0.
- rdy=0: all state and outputs hold, including a pending rob_enable or jump_wrong pulse, which is consumed at the next rdy=1 edge.

## Timing
- Reset (rst_n low, asynchronous): all outputs registered to 0 except rob_empty=1; rob_free_rename=0; all busy bits=0; FSM=RUN.
- Issue to tag visible: tag is known combinationally before the edge; the entry is busy after that edge.
- CDB to commit: an entry written by CDB at edge N can commit at edge N+1 at the earliest, so rob_enable is high in cycle N+1..N+2.
- Misprediction: rob_enable for the branch is high in cycle C, jump_wrong is high in cycle C+1, and the first new issue is accepted at the edge ending cycle C+1 is ignored, so the first new issue lands at the following edge. Tags restart at 0.
- Wrap-around: tail/head from ROB_DEPTH-1 roll to 0; full/empty decisions use count only.

## Test plan
- Reset then three issues (rd=1,2,3) -> tags 0,1,2; rob_free_rename=3; rob_empty=0; no rob_enable.
- CDB tag1=0x22 then tag0=0x11 -> commits in order: (rd1,tag0,0x11) then (rd2,tag1,0x22) on consecutive cycles; tag2 is held.
- Fill 16 entries -> rob_full=1; a 17th issue is dropped; commit one -> rob_full=0; next issue gets tag 0 (wrap).
- Query tag5 in the same cycle as a CDB tag5=0xABCD -> query_ready=1, value=0xABCD; tag with no result -> query_ready=0.
- Mispredicted jalr (rd=1, value=0x1004, target=0x2000) at head with younger entries -> rob_enable with 0x1004, next cycle jump_wrong=1 and jump_target=0x2000, then rob_empty=1 and rob_free_rename=0.
- rdy=0 while rob_enable=1 for 3 cycles -> rob_enable held, head unchanged; the commit completes once rdy=1; rst_n asserted mid-flush -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Decoder / CDB / commit-port bundle of the reorder buffer.
// Latency: n/a (wires only); outputs are produced by the buffer as documented there.
// Backpressure: rob_full tells the decoder to stall; the buffer drops issues while full.
`default_nettype none

interface reorder_buffer_if #(
    parameter int IDX_W  = 4,
    parameter int REG_W  = 5,
    parameter int DATA_W = 32
);
    // Allocation from the decoder
    logic              issue_valid;
    logic              issue_has_rd;
    logic [REG_W-1:0]  issue_rd;
    logic [IDX_W-1:0]  rob_free_rename;
    logic              rob_full;
    logic              rob_empty;

    // Operand resolution by tag
    logic [IDX_W-1:0]  query_rename1;
    logic [IDX_W-1:0]  query_rename2;
    logic              query_ready1;
    logic              query_ready2;
    logic [DATA_W-1:0] query_value1;
    logic [DATA_W-1:0] query_value2;

    // Common data bus
    logic              cdb_valid;
    logic [IDX_W-1:0]  cdb_rename;
    logic [DATA_W-1:0] cdb_value;
    logic              cdb_mispredict;
    logic [DATA_W-1:0] cdb_target;

    // In-order commit and pipeline flush
    logic              rob_enable;
    logic [REG_W-1:0]  rob_commit_index;
    logic [IDX_W-1:0]  rob_commit_rename;
    logic [DATA_W-1:0] rob_commit_value;
    logic              jump_wrong;
    logic [DATA_W-1:0] jump_target;

    // Pipeline side: decoder, execution units and register file
    modport master (
        output issue_valid, issue_has_rd, issue_rd,
        output query_rename1, query_rename2,
        output cdb_valid, cdb_rename, cdb_value, cdb_mispredict, cdb_target,
        input  rob_free_rename, rob_full, rob_empty,
        input  query_ready1, query_ready2, query_value1, query_value2,
        input  rob_enable, rob_commit_index, rob_commit_rename, rob_commit_value,
        input  jump_wrong, jump_target
    );

    // Reorder buffer side
    modport slave (
        input  issue_valid, issue_has_rd, issue_rd,
        input  query_rename1, query_rename2,
        input  cdb_valid, cdb_rename, cdb_value, cdb_mispredict, cdb_target,
        output rob_free_rename, rob_full, rob_empty,
        output query_ready1, query_ready2, query_value1, query_value2,
        output rob_enable, rob_commit_index, rob_commit_rename, rob_commit_value,
        output jump_wrong, jump_target
    );
endinterface

`default_nettype wire

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates rename tags, captures CDB results, retires in program order.
// Latency: CDB write at edge N commits at edge N+1 earliest; mispredict flush pulse one cycle after the commit pulse.
// Backpressure: issues while full are dropped (decoder stalls on rob_full); rdy=0 freezes all state and outputs.
`default_nettype none

module reorder_buffer #(
    parameter int ROB_DEPTH = 16,
    parameter int IDX_W     = 4,
    parameter int REG_W     = 5,
    parameter int DATA_W    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rdy,
    reorder_buffer_if.slave rob_if
);
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(ROB_DEPTH);

    // Global pointers and sequencer
    state_t             state_q;
    logic [IDX_W-1:0]   head_q;
    logic [IDX_W-1:0]   tail_q;
    logic [IDX_W:0]     count_q;
    logic [IDX_W:0]     count_d;

    // Per-entry flags (reset) and payload (not reset, always written before use)
    logic [ROB_DEPTH-1:0] busy_q;
    logic [ROB_DEPTH-1:0] ready_q;
    logic [ROB_DEPTH-1:0] has_rd_q;
    logic [ROB_DEPTH-1:0] mispredict_q;
    logic [REG_W-1:0]     rd_q     [ROB_DEPTH];
    logic [DATA_W-1:0]    value_q  [ROB_DEPTH];
    logic [DATA_W-1:0]    target_q [ROB_DEPTH];

    // Registered outputs
    logic               rob_enable_q;
    logic [REG_W-1:0]   commit_index_q;
    logic [IDX_W-1:0]   commit_rename_q;
    logic [DATA_W-1:0]  commit_value_q;
    logic               jump_wrong_q;
    logic [DATA_W-1:0]  jump_target_q;

    // Per-cycle decisions
    logic               full;
    logic               empty;
    logic               accepting;
    logic               do_issue;
    logic               do_wb;
    logic               do_commit;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // New work is only taken in RUN and not during the jump_wrong cycle, so a
    // redirect squashes everything from the mispredict commit up to the flush.
    assign accepting = (state_q == ST_RUN) && !jump_wrong_q;
    assign do_issue  = accepting && rob_if.issue_valid && !full;
    assign do_wb     = accepting && rob_if.cdb_valid && busy_q[rob_if.cdb_rename];
    assign do_commit = accepting && !empty && busy_q[head_q] && ready_q[head_q];

    // Occupancy: one allocation and one retirement cancel out
    always_comb begin
        count_d = count_q + (IDX_W+1)'(do_issue) - (IDX_W+1)'(do_commit);
    end

    // Control state, commit port and RUN/FLUSH sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_RUN;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            busy_q          <= '0;
            ready_q         <= '0;
            rob_enable_q    <= 1'b0;
            commit_index_q  <= '0;
            commit_rename_q <= '0;
            commit_value_q  <= '0;
            jump_wrong_q    <= 1'b0;
            jump_target_q   <= '0;
        end else if (rdy) begin
            case (state_q)
                ST_RUN: begin
                    jump_wrong_q <= 1'b0;
                    rob_enable_q <= 1'b0;
                    if (do_issue) begin
                        busy_q[tail_q]  <= 1'b1;
                        ready_q[tail_q] <= 1'b0;
                        tail_q          <= tail_q + IDX_ONE;
                    end
                    if (do_wb) begin
                        ready_q[rob_if.cdb_rename] <= 1'b1;
                    end
                    // Retirement is listed last so it wins over a CDB rewrite of the head
                    if (do_commit) begin
                        busy_q[head_q]  <= 1'b0;
                        ready_q[head_q] <= 1'b0;
                        head_q          <= head_q + IDX_ONE;
                        rob_enable_q    <= has_rd_q[head_q];
                        commit_index_q  <= rd_q[head_q];
                        commit_rename_q <= head_q;
                        commit_value_q  <= value_q[head_q];
                        if (mispredict_q[head_q]) begin
                            jump_target_q <= target_q[head_q];
                            state_q       <= ST_FLUSH;
                        end
                    end
                    count_q <= count_d;
                end
                default: begin
                    // The branch has retired; drop every younger entry and redirect
                    jump_wrong_q <= 1'b1;
                    rob_enable_q <= 1'b0;
                    busy_q       <= '0;
                    ready_q      <= '0;
                    head_q       <= '0;
                    tail_q       <= '0;
                    count_q      <= '0;
                    state_q      <= ST_RUN;
                end
            endcase
        end
    end

    // Entry payload capture on allocation and on CDB writeback
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (do_issue) begin
                has_rd_q[tail_q]     <= rob_if.issue_has_rd;
                rd_q[tail_q]         <= rob_if.issue_rd;
                mispredict_q[tail_q] <= 1'b0;
            end
            if (do_wb) begin
                value_q[rob_if.cdb_rename]      <= rob_if.cdb_value;
                mispredict_q[rob_if.cdb_rename] <= rob_if.cdb_mispredict;
                target_q[rob_if.cdb_rename]     <= rob_if.cdb_target;
            end
        end
    end

    // Operand lookup with same-cycle CDB bypass
    always_comb begin
        rob_if.query_ready1 = busy_q[rob_if.query_rename1] && ready_q[rob_if.query_rename1];
        rob_if.query_value1 = value_q[rob_if.query_rename1];
        rob_if.query_ready2 = busy_q[rob_if.query_rename2] && ready_q[rob_if.query_rename2];
        rob_if.query_value2 = value_q[rob_if.query_rename2];
        if (rob_if.cdb_valid && (rob_if.cdb_rename == rob_if.query_rename1)) begin
            rob_if.query_ready1 = 1'b1;
            rob_if.query_value1 = rob_if.cdb_value;
        end
        if (rob_if.cdb_valid && (rob_if.cdb_rename == rob_if.query_rename2)) begin
            rob_if.query_ready2 = 1'b1;
            rob_if.query_value2 = rob_if.cdb_value;
        end
    end

    assign rob_if.rob_full          = full;
    assign rob_if.rob_empty         = empty;
    assign rob_if.rob_free_rename   = tail_q;
    assign rob_if.rob_enable        = rob_enable_q;
    assign rob_if.rob_commit_index  = commit_index_q;
    assign rob_if.rob_commit_rename = commit_rename_q;
    assign rob_if.rob_commit_value  = commit_value_q;
    assign rob_if.jump_wrong        = jump_wrong_q;
    assign rob_if.jump_target       = jump_target_q;

endmodule

`default_nettype wire
